// File: rtl/stb_seq.sv
// Calibration sequencer for a strobe generator: kicks NMEAS period detections, checks the
// spread of each run against a tolerance, retries rejected runs and publishes the average.
module stb_seq #(
   parameter int unsigned T_CNT_WIDTH  = 32,
   parameter int unsigned LOG2_NMEAS   = 2,
   parameter int unsigned MAX_RETRY    = 3,
   parameter int unsigned KICK_TIMEOUT = 4
) (
   input  logic                   clk_i,
   input  logic                   arst_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [T_CNT_WIDTH-1:0] tol_i,
   input  logic                   gen_rdy_i,
   input  logic                   gen_err_i,
   input  logic [T_CNT_WIDTH-1:0] gen_period_i,
   output logic                   run_det_o,
   output logic                   oe_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   fail_o,
   output logic [T_CNT_WIDTH-1:0] period_o,
   output logic [T_CNT_WIDTH-1:0] spread_o,
   output logic [1:0]             retry_o
);

   localparam int unsigned SumW = T_CNT_WIDTH + LOG2_NMEAS;
   localparam int unsigned TmoW = $clog2(KICK_TIMEOUT + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(KICK_TIMEOUT - 1);
   localparam logic [1:0] RetryMax = 2'(MAX_RETRY);

   typedef enum logic [2:0] {
      StIdle, StKick, StWaitBusy, StWaitRdy, StEval, StDone, StFail
   } state_e;

   state_e                 state_q, state_d;
   logic [SumW-1:0]        sum_q, sum_d;
   logic [T_CNT_WIDTH-1:0] min_q, min_d;
   logic [T_CNT_WIDTH-1:0] max_q, max_d;
   logic [T_CNT_WIDTH-1:0] period_q, period_d;
   logic [T_CNT_WIDTH-1:0] spread_q, spread_d;
   logic [T_CNT_WIDTH-1:0] spread_now;
   logic [LOG2_NMEAS:0]    cnt_q, cnt_d;
   logic [TmoW-1:0]        tmo_q, tmo_d;
   logic [1:0]             retry_q, retry_d;
   logic                   run_det_q, run_det_d;
   logic                   oe_q, oe_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   fail_q, fail_d;
   logic                   clr_acc;
   logic                   reject;

   always_comb begin
      state_d    = state_q;
      sum_d      = sum_q;
      min_d      = min_q;
      max_d      = max_q;
      period_d   = period_q;
      spread_d   = spread_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      retry_d    = retry_q;
      clr_acc    = 1'b0;
      reject     = 1'b0;
      spread_now = max_q - min_q;

      if (abort_i) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle, StDone, StFail: begin
               if (start_i) begin
                  state_d = StKick;
                  clr_acc = 1'b1;
                  retry_d = '0;
               end
            end
            StKick: begin
               state_d = StWaitBusy;
               tmo_d   = '0;
            end
            StWaitBusy: begin
               if (!gen_rdy_i) begin
                  state_d = StWaitRdy;
               end else if (tmo_q == TmoLast) begin
                  state_d = StFail;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            StWaitRdy: begin
               // Entered only with gen_rdy_i low, so any high cycle here is the first one.
               if (gen_rdy_i) begin
                  if (gen_err_i) begin
                     reject = 1'b1;
                  end else begin
                     sum_d = sum_q + SumW'(gen_period_i);
                     if (gen_period_i < min_q) min_d = gen_period_i;
                     if (gen_period_i > max_q) max_d = gen_period_i;
                     cnt_d   = cnt_q + 1'b1;
                     state_d = cnt_d[LOG2_NMEAS] ? StEval : StKick;
                  end
               end
            end
            StEval: begin
               spread_d = spread_now;
               if (spread_now <= tol_i) begin
                  period_d = sum_q[SumW-1:LOG2_NMEAS];
                  state_d  = StDone;
               end else begin
                  reject = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase

         if (reject) begin
            if (retry_q < RetryMax) begin
               retry_d = retry_q + 1'b1;
               clr_acc = 1'b1;
               state_d = StKick;
            end else begin
               state_d = StFail;
            end
         end
      end

      if (clr_acc) begin
         sum_d = '0;
         min_d = '1;
         max_d = '0;
         cnt_d = '0;
      end

      // Outputs are registered copies of the next state's flags.
      run_det_d = (state_d == StKick);
      oe_d      = (state_d == StDone);
      done_d    = (state_d == StDone);
      fail_d    = (state_d == StFail);
      busy_d    = (state_d == StKick) || (state_d == StWaitBusy) ||
                  (state_d == StWaitRdy) || (state_d == StEval);
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q   <= StIdle;
         sum_q     <= '0;
         min_q     <= '0;
         max_q     <= '0;
         period_q  <= '0;
         spread_q  <= '0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         retry_q   <= '0;
         run_det_q <= 1'b0;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sum_q     <= sum_d;
         min_q     <= min_d;
         max_q     <= max_d;
         period_q  <= period_d;
         spread_q  <= spread_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         retry_q   <= retry_d;
         run_det_q <= run_det_d;
         oe_q      <= oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
      end
   end

   assign run_det_o = run_det_q;
   assign oe_o      = oe_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign fail_o    = fail_q;
   assign period_o  = period_q;
   assign spread_o  = spread_q;
   assign retry_o   = retry_q;

endmodule

// File: tb/tb_stb_seq.sv
// Scoreboard bench for stb_seq: a generator model answers kicks from a sample queue and a
// monitor pops the expected result whenever done_o or fail_o rises.
module tb_stb_seq;

   localparam int unsigned W = 32;

   logic         clk_i = 1'b0;
   logic         arst_i, start_i, abort_i;
   logic [W-1:0] tol_i;
   logic         gen_rdy_i, gen_err_i;
   logic [W-1:0] gen_period_i;
   logic         run_det_o, oe_o, busy_o, done_o, fail_o;
   logic [W-1:0] period_o, spread_o;
   logic [1:0]   retry_o;

   always #5 clk_i = ~clk_i;

   stb_seq #(
      .T_CNT_WIDTH (W),
      .LOG2_NMEAS  (2),
      .MAX_RETRY   (3),
      .KICK_TIMEOUT(4)
   ) dut (
      .clk_i       (clk_i),
      .arst_i      (arst_i),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .tol_i       (tol_i),
      .gen_rdy_i   (gen_rdy_i),
      .gen_err_i   (gen_err_i),
      .gen_period_i(gen_period_i),
      .run_det_o   (run_det_o),
      .oe_o        (oe_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .fail_o      (fail_o),
      .period_o    (period_o),
      .spread_o    (spread_o),
      .retry_o     (retry_o)
   );

   typedef struct {
      logic [W-1:0] period;
      logic         err;
   } smp_t;

   typedef struct {
      logic         done;
      logic         fail;
      logic         oe;
      logic [W-1:0] period;
      logic [W-1:0] spread;
      logic [1:0]   retry;
      int           kicks;
   } exp_t;

   smp_t smp_q[$];
   exp_t sb[$];
   int   n_vec    = 0;
   int   n_err    = 0;
   int   kicks    = 0;
   int   gen_mode = 0;  // 0 normal, 1 rdy stuck high, 2 rdy held low after kick
   logic prev_end = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_smp(input logic [W-1:0] p, input logic e);
      smp_t s;
      s.period = p;
      s.err    = e;
      smp_q.push_back(s);
   endtask

   task automatic expect_end(input logic d, input logic f, input logic [W-1:0] p,
                             input logic [W-1:0] s, input logic [1:0] r, input int nk);
      exp_t e;
      e.done   = d;
      e.fail   = f;
      e.oe     = d;
      e.period = p;
      e.spread = s;
      e.retry  = r;
      e.kicks  = kicks + nk;
      sb.push_back(e);
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_sb(input int budget);
      int i;
      i = 0;
      while (sb.size() != 0 && i < budget) begin
         @(posedge clk_i); #1;
         i++;
      end
      check("sb_drained", sb.size(), 0);
      sb.delete();
   endtask

   task automatic wait_kick(input int budget);
      int i;
      i = 0;
      while (!run_det_o && i < budget) begin
         @(posedge clk_i); #1;
         i++;
      end
      check("kick_seen", run_det_o, 1);
   endtask

   // Generator model
   initial begin
      smp_t s;
      gen_rdy_i    = 1'b1;
      gen_err_i    = 1'b0;
      gen_period_i = '0;
      forever begin
         @(posedge clk_i); #1;
         if (run_det_o && gen_mode != 1) begin
            gen_rdy_i = 1'b0;
            if (gen_mode == 2) begin
               while (gen_mode == 2) @(posedge clk_i);
               #1 gen_rdy_i = 1'b1;
            end else begin
               repeat (3) @(posedge clk_i);
               #1;
               if (smp_q.size() > 0) begin
                  s = smp_q.pop_front();
               end else begin
                  s.period = '0;
                  s.err    = 1'b1;
               end
               gen_period_i = s.period;
               gen_err_i    = s.err;
               gen_rdy_i    = 1'b1;
            end
         end
      end
   end

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (run_det_o) kicks++;
         if ((done_o || fail_o) && !prev_end) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("done", done_o, e.done);
               check("fail", fail_o, e.fail);
               check("oe", oe_o, e.oe);
               check("busy", busy_o, 0);
               check("period", period_o, e.period);
               check("spread", spread_o, e.spread);
               check("retry", retry_o, e.retry);
               check("kicks", kicks, e.kicks);
            end
         end
         prev_end = done_o || fail_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int k;
      arst_i  = 1'b1;
      start_i = 1'b0;
      abort_i = 1'b0;
      tol_i   = 32'd8;
      repeat (2) @(posedge clk_i); #1;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_fail", fail_o, 0);
      check("rst_oe", oe_o, 0);
      check("rst_run_det", run_det_o, 0);
      check("rst_period", period_o, 0);
      check("rst_spread", spread_o, 0);
      check("rst_retry", retry_o, 0);
      arst_i = 1'b0;
      @(posedge clk_i); #1;

      // Every sample errors: four runs, then fail with nothing ever accepted
      repeat (4) push_smp(32'd1000, 1'b1);
      expect_end(1'b0, 1'b1, 32'd0, 32'd0, 2'd3, 4);
      pulse_start();
      wait_sb(300);

      // Clean run
      push_smp(32'd1000, 1'b0);
      push_smp(32'd1002, 1'b0);
      push_smp(32'd998, 1'b0);
      push_smp(32'd1000, 1'b0);
      expect_end(1'b1, 1'b0, 32'd1000, 32'd4, 2'd0, 4);
      pulse_start();
      wait_sb(300);

      // Spread 100 rejected once, retry accepted
      push_smp(32'd1000, 1'b0);
      push_smp(32'd1000, 1'b0);
      push_smp(32'd1000, 1'b0);
      push_smp(32'd1100, 1'b0);
      repeat (4) push_smp(32'd1000, 1'b0);
      expect_end(1'b1, 1'b0, 32'd1000, 32'd0, 2'd1, 8);
      pulse_start();
      wait_sb(400);

      // Sum 8006 truncates to 2001
      push_smp(32'd2000, 1'b0);
      push_smp(32'd2003, 1'b0);
      push_smp(32'd2001, 1'b0);
      push_smp(32'd2002, 1'b0);
      expect_end(1'b1, 1'b0, 32'd2001, 32'd3, 2'd0, 4);
      pulse_start();
      wait_sb(300);

      // gen_rdy_i stuck high: kick timeout
      gen_mode = 1;
      expect_end(1'b0, 1'b1, 32'd2001, 32'd3, 2'd0, 1);
      pulse_start();
      wait_kick(10);
      n = 0;
      do begin
         @(posedge clk_i); #1;
         n++;
      end while (!fail_o && n < 20);
      check("timeout_latency", n, 5);
      wait_sb(10);
      gen_mode = 0;

      // abort together with start while in WAIT_RDY
      gen_mode = 2;
      pulse_start();
      wait_kick(10);
      repeat (2) @(posedge clk_i); #1;
      check("pre_abort_busy", busy_o, 1);
      abort_i = 1'b1;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      start_i = 1'b0;
      check("abort_busy", busy_o, 0);
      check("abort_done", done_o, 0);
      check("abort_fail", fail_o, 0);
      check("abort_oe", oe_o, 0);
      check("abort_run_det", run_det_o, 0);
      check("abort_period", period_o, 2001);
      k = kicks;
      gen_mode = 0;
      repeat (10) @(posedge clk_i); #1;
      check("abort_no_kick", kicks - k, 0);

      // Asynchronous reset during WAIT_RDY, then a fresh run at the tolerance boundary
      gen_mode = 2;
      pulse_start();
      wait_kick(10);
      repeat (2) @(posedge clk_i);
      #2 arst_i = 1'b1;
      #1;
      check("arst_busy", busy_o, 0);
      check("arst_oe", oe_o, 0);
      check("arst_done", done_o, 0);
      check("arst_fail", fail_o, 0);
      check("arst_run_det", run_det_o, 0);
      check("arst_period", period_o, 0);
      check("arst_spread", spread_o, 0);
      check("arst_retry", retry_o, 0);
      gen_mode = 0;
      repeat (2) @(posedge clk_i); #1;
      arst_i = 1'b0;
      k = kicks;
      repeat (5) @(posedge clk_i); #1;
      check("arst_no_kick", kicks - k, 0);
      push_smp(32'd1496, 1'b0);
      push_smp(32'd1500, 1'b0);
      push_smp(32'd1504, 1'b0);
      push_smp(32'd1500, 1'b0);
      expect_end(1'b1, 1'b0, 32'd1500, 32'd8, 2'd0, 4);
      pulse_start();
      wait_sb(300);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
